// File: rtl/window_seq_pkg.sv
// Shared state encoding and sizing helpers for the window frame sequencer.
package window_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // The ring holds two frames so one can fill while the other replays.
  localparam int BUF_FRAMES     = 2;
  localparam int OUT_FIFO_DEPTH = 3;

  function automatic int buf_depth(input int frame_len);
    return BUF_FRAMES * frame_len;
  endfunction

  function automatic int frame_advance(input int frame_len, input int hop_len, input bit overlap);
    return overlap ? hop_len : frame_len;
  endfunction

endpackage

// File: rtl/xilinx_simple_dual_port_1_clock_ram.sv
// Simple dual-port RAM, one clock: port A writes, port B reads.
// HIGH_PERFORMANCE adds an output register, giving a 2-cycle read latency.
module xilinx_simple_dual_port_1_clock_ram #(
  parameter int    RAM_WIDTH       = 8,
  parameter int    RAM_DEPTH       = 16,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                         clka,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         enb,
  input  logic                         regceb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end

  always_ff @(posedge clka) begin
    if (enb) ram_data <= mem[addrb];
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    assign doutb = ram_data;
  end else begin : g_high_performance
    logic [RAM_WIDTH-1:0] dout_q;
    always_ff @(posedge clka) begin
      if (regceb) dout_q <= ram_data;
    end
    assign doutb = dout_q;
  end

endmodule

// File: rtl/window_frame_sequencer.sv
// Ring-buffers audio samples and replays each full frame as a burst with its in-frame index.
// Define FRAME_OVERLAP_EN to advance frames by HOP_LEN; otherwise frames are disjoint.
module window_frame_sequencer
  import window_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4096,
  parameter int HOP_LEN    = 2048
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [DATA_WIDTH-1:0]        in_sample,
  input  logic                         audio_sample_valid,
  output logic [DATA_WIDTH-1:0]        out_sample,
  output logic [$clog2(FRAME_LEN)-1:0] coeff_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_first,
  output logic                         frame_last,
  output logic                         busy,
  output logic                         overrun
);

`ifdef FRAME_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int BUF_DEPTH = buf_depth(FRAME_LEN);
  localparam int AW        = $clog2(BUF_DEPTH);
  localparam int PW        = AW + 1;
  localparam int ADV       = frame_advance(FRAME_LEN, HOP_LEN, OVERLAP);

  localparam logic [PW-1:0]    BUF_P    = PW'(BUF_DEPTH);
  localparam logic [PW-1:0]    FRAME_P  = PW'(FRAME_LEN);
  localparam logic [PW-1:0]    ADV_P    = PW'(ADV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_W-1:0]      idx;
    logic                  first;
    logic                  last;
  } entry_t;

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    wp_q, fs_q, fill;
  logic             wr_en, issue, fs_advance;
  logic [AW-1:0]    rd_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Read pipeline tracking, aligned with the RAM's two register stages.
  logic             rd_v1, rd_v2;
  logic [IDX_W-1:0] rd_idx1, rd_idx2;

  entry_t      fifo_mem [OUT_FIFO_DEPTH];
  logic [1:0]  fifo_rd, fifo_wr, fifo_cnt;
  logic [2:0]  occupancy;
  entry_t      ram_entry, head;
  logic        fire, bypass, push, pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(OUT_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign fill    = wp_q - fs_q;
  assign wr_en   = audio_sample_valid && (fill < BUF_P);
  assign rd_addr = fs_q[AW-1:0] + {1'b0, idx_q};

  xilinx_simple_dual_port_1_clock_ram #(
    .RAM_WIDTH       (DATA_WIDTH),
    .RAM_DEPTH       (BUF_DEPTH),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_ring (
    .clka   (clk_in),
    .wea    (wr_en),
    .addra  (wp_q[AW-1:0]),
    .dina   (in_sample),
    .enb    (1'b1),
    .regceb (1'b1),
    .addrb  (rd_addr),
    .doutb  (ram_dout)
  );

  // RAM output acts as a bypass slot in front of the FIFO, so data reaches
  // the port the cycle it leaves the RAM and the head never moves while stalled.
  always_comb begin
    ram_entry       = '0;
    ram_entry.data  = ram_dout;
    ram_entry.idx   = rd_idx2;
    ram_entry.first = (rd_idx2 == '0);
    ram_entry.last  = (rd_idx2 == IDX_LAST);
    if (fifo_cnt != 2'd0) head = fifo_mem[fifo_rd];
    else if (rd_v2)       head = ram_entry;
    else                  head = '0;
  end

  assign out_valid   = (fifo_cnt != 2'd0) || rd_v2;
  assign out_sample  = head.data;
  assign coeff_addr  = head.idx;
  assign frame_first = head.first;
  assign frame_last  = head.last;
  assign busy        = (state_q != IDLE);

  assign fire      = out_valid && out_ready;
  assign bypass    = (fifo_cnt == 2'd0) && rd_v2 && out_ready;
  assign push      = rd_v2 && !bypass;
  assign pop       = fire && (fifo_cnt != 2'd0);
  assign occupancy = {1'b0, fifo_cnt} + {2'b0, rd_v1} + {2'b0, rd_v2};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    issue      = 1'b0;
    fs_advance = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (fill >= FRAME_P) state_d = READ;
      end
      READ: begin
        issue = (occupancy < 3'(OUT_FIFO_DEPTH));
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fire && head.last) begin
          fs_advance = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wp_q    <= '0;
      fs_q    <= '0;
      overrun <= 1'b0;
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      rd_idx1 <= '0;
      rd_idx2 <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (audio_sample_valid && !wr_en) overrun <= 1'b1;
      if (fs_advance) fs_q <= fs_q + ADV_P;
      rd_v1   <= issue;
      rd_v2   <= rd_v1;
      rd_idx1 <= idx_q;
      rd_idx2 <= rd_idx1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr] <= ram_entry;
        fifo_wr           <= ptr_next(fifo_wr);
      end
      if (pop) fifo_rd <= ptr_next(fifo_rd);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_window_frame_sequencer.sv
// Directed bench for window_frame_sequencer with FRAME_LEN=8, HOP_LEN=4.
// Works with FRAME_OVERLAP_EN defined or undefined.
module tb_window_frame_sequencer;

  localparam int DW = 8;
  localparam int FL = 8;
  localparam int HL = 4;
  localparam int IW = 3;
`ifdef FRAME_OVERLAP_EN
  localparam int ADV = HL;
`else
  localparam int ADV = FL;
`endif

  typedef struct {
    logic [DW-1:0] s;
    logic [IW-1:0] a;
    logic          f;
    logic          l;
    int            cyc;
  } beat_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [DW-1:0] in_sample = '0;
  logic          audio_sample_valid = 1'b0;
  logic [DW-1:0] out_sample;
  logic [IW-1:0] coeff_addr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          frame_first, frame_last, busy, overrun;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            drive_cyc = 0;
  int            ready_mode = 1;
  logic [DW-1:0] exp_q[$];
  beat_t         got_q[$];
  beat_t         held;
  logic          stalled = 1'b0;

  window_frame_sequencer #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .HOP_LEN    (HL)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .in_sample          (in_sample),
    .audio_sample_valid (audio_sample_valid),
    .out_sample         (out_sample),
    .coeff_addr         (coeff_addr),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .frame_first        (frame_first),
    .frame_last         (frame_last),
    .busy               (busy),
    .overrun            (overrun)
  );

  // Clock and cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: applies the out_ready policy, records accepted beats,
  // and checks that a stalled head holds until it is taken.
  always @(negedge clk_in) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst_in) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sample", 32'(out_sample), 32'(held.s));
        check("hold_coeff", 32'(coeff_addr), 32'(held.a));
        check("hold_last", 32'(frame_last), 32'(held.l));
      end
      held    = '{out_sample, coeff_addr, frame_first, frame_last, cyc};
      stalled = out_valid && !out_ready;
      if (out_valid && out_ready) got_q.push_back(held);
    end
  end

  // Driver tasks
  task automatic feed(input int first, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      audio_sample_valid = 1'b1;
      in_sample          = DW'(first + i);
      drive_cyc          = cyc;
      for (int g = 1; g < gap; g++) begin
        @(negedge clk_in);
        audio_sample_valid = 1'b0;
      end
    end
    @(negedge clk_in);
    audio_sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in             = 1'b1;
    audio_sample_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(posedge clk_in);
      #2;
      t++;
    end
    check("beat_count", 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic expect_frame(input int first);
    for (int i = 0; i < FL; i++) exp_q.push_back(DW'(first + i));
  endtask

  // Scoreboard: compares one frame of accepted beats against exp_q.
  task automatic check_frame(input string tag);
    beat_t         b;
    logic [DW-1:0] e;
    for (int i = 0; i < FL; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      b = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_sample"}, 32'(b.s), 32'(e));
      check({tag, "_coeff"}, 32'(b.a), 32'(i));
      check({tag, "_first"}, 32'(b.f), 32'(i == 0));
      check({tag, "_last"}, 32'(b.l), 32'(i == FL - 1));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sample"}, 32'(out_sample), 32'd0);
    check({tag, "_coeff"}, 32'(coeff_addr), 32'd0);
    check({tag, "_first"}, 32'(frame_first), 32'd0);
    check({tag, "_last"}, 32'(frame_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_in);
    check_outputs_zero("reset");
    do_reset();

    // First frame with out_ready high: latency and contents
    ready_mode = 1;
    feed(1, FL, 1);
    wait_beats(FL, 100);
    if (got_q.size() > 0) check("latency", 32'(got_q[0].cyc - drive_cyc), 32'd4);
    expect_frame(1);
    check_frame("frame1");

    // Second frame after one hop of new samples
    feed(FL + 1, ADV, 1);
    wait_beats(FL, 100);
    expect_frame(1 + ADV);
    check_frame("frame2");

    // Four frames with random out_ready and sparse input
    ready_mode = 2;
    for (int j = 2; j < 6; j++) expect_frame(1 + j * ADV);
    feed(FL + 1 + ADV, 4 * ADV, 6);
    wait_beats(4 * FL, 3000);
    for (int j = 0; j < 4; j++) check_frame("rand");
    check("rand_overrun", 32'(overrun), 32'd0);

    // Overrun: stall output, fill the ring, then one extra sample
    do_reset();
    ready_mode = 0;
    feed(1, 2 * FL, 1);
    check("ovr_before", 32'(overrun), 32'd0);
    feed(2 * FL + 1, 1, 1);
    check("ovr_after", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    check("ovr_head_valid", 32'(out_valid), 32'd1);
    check("ovr_head_sample", 32'(out_sample), 32'd1);
    check("ovr_head_first", 32'(frame_first), 32'd1);
    ready_mode = 1;
    wait_beats(FL, 200);
    expect_frame(1);
    check_frame("ovr_frame");
    repeat (80) @(posedge clk_in);
    #2;
    check("ovr_remaining_beats", 32'(got_q.size()), 32'(FL * (FL / ADV + 1) - FL));
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a frame, then a fresh frame
    do_reset();
    ready_mode = 1;
    feed(1, FL, 1);
    wait_beats(3, 100);
    rst_in = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk_in);
    rst_in = 1'b0;
    got_q.delete();
    exp_q.delete();
    feed(20, FL, 1);
    wait_beats(FL, 100);
    if (got_q.size() > 0) check("post_rst_latency", 32'(got_q[0].cyc - drive_cyc), 32'd4);
    expect_frame(20);
    check_frame("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
